// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, a single-entry
// instruction buffer, redirect/kill handling and a saturating stall counter.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        EnF,
  input  logic        RedirectD,
  input  logic [31:0] PCTargetD,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] PCF,
  output logic        ValidF,
  output logic [31:0] StallCntF
);

  typedef enum logic {S_REQ = 1'b0, S_READY = 1'b1} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] req_addr_reg;
  logic [31:0] buf_reg;
  logic [31:0] stall_cnt_reg;
  logic        kill_reg;

  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        redirect_now;

  assign target       = PCTargetD & 32'hFFFF_FFFC;
  assign pc_plus4     = pc_reg + 32'd4;
  assign redirect_now = EnF & RedirectD;
  // Newest PC: the redirect target if one is taken this edge, else the current PC.
  assign pc_next      = redirect_now ? target : pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_REQ;
      pc_reg        <= 32'd0;
      req_addr_reg  <= 32'd0;
      buf_reg       <= 32'd0;
      stall_cnt_reg <= 32'd0;
      kill_reg      <= 1'b0;
    end else begin
      if (EnF && state_reg == S_REQ && stall_cnt_reg != 32'hFFFF_FFFF)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;

      if (state_reg == S_REQ) begin
        if (IMemAck) begin
          if (kill_reg || redirect_now) begin
            // Returning data belongs to a squashed path: drop it and re-request.
            pc_reg       <= pc_next;
            req_addr_reg <= pc_next;
            kill_reg     <= 1'b0;
          end else begin
            buf_reg   <= IMemRdata;
            state_reg <= S_READY;
          end
        end else if (redirect_now) begin
          // Request address must stay stable until the in-flight ack arrives.
          pc_reg   <= target;
          kill_reg <= 1'b1;
        end
      end else if (EnF) begin
        pc_reg       <= RedirectD ? target : pc_plus4;
        req_addr_reg <= RedirectD ? target : pc_plus4;
        state_reg    <= S_REQ;
      end
    end
  end

  assign IMemReq   = (state_reg == S_REQ);
  assign IMemAddr  = req_addr_reg;
  assign ValidF    = (state_reg == S_READY);
  assign InstrF    = ValidF ? buf_reg : 32'd0;
  assign PCPlus4F  = ValidF ? pc_plus4 : 32'd0;
  assign PCF       = pc_reg;
  assign StallCntF = stall_cnt_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a fetch-transaction model checked every cycle,
// plus hand-computed literal expectations along the scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        EnF = 1'b0;
  logic        RedirectD = 1'b0;
  logic [31:0] PCTargetD = 32'd0;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemRdata = 32'd0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  logic [31:0] PCF;
  logic        ValidF;
  logic [31:0] StallCntF;

  fetch_unit dut (
    .clk(clk), .reset(reset), .EnF(EnF), .RedirectD(RedirectD),
    .PCTargetD(PCTargetD), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemAck(IMemAck), .IMemRdata(IMemRdata), .InstrF(InstrF),
    .PCPlus4F(PCPlus4F), .PCF(PCF), .ValidF(ValidF), .StallCntF(StallCntF)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Model: the fetch stage either holds a delivered instruction (m_have) or is
  // waiting on memory for m_addr; m_stale marks a reply for an abandoned path.
  logic [31:0] m_pc = 32'd0, m_addr = 32'd0, m_instr = 32'd0, m_cnt = 32'd0;
  logic        m_have = 1'b0, m_stale = 1'b0, chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'd0; m_addr = 32'd0; m_instr = 32'd0; m_cnt = 32'd0;
      m_have = 1'b0; m_stale = 1'b0;
    end else begin
      if (EnF && !m_have && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_have) begin
        if (EnF) begin
          m_pc   = RedirectD ? (PCTargetD & 32'hFFFF_FFFC) : m_pc + 32'd4;
          m_addr = m_pc;
          m_have = 1'b0;
        end
      end else begin
        if (EnF && RedirectD) m_pc = PCTargetD & 32'hFFFF_FFFC;
        if (IMemAck && (m_stale || (EnF && RedirectD))) begin
          m_addr  = m_pc;
          m_stale = 1'b0;
        end else if (IMemAck) begin
          m_instr = IMemRdata;
          m_have  = 1'b1;
        end else if (EnF && RedirectD) begin
          m_stale = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("IMemReq", 32'(IMemReq), 32'(!m_have));
      if (!m_have) check("IMemAddr", IMemAddr, m_addr);
      check("ValidF", 32'(ValidF), 32'(m_have));
      check("InstrF", InstrF, m_have ? m_instr : 32'd0);
      check("PCPlus4F", PCPlus4F, m_have ? m_pc + 32'd4 : 32'd0);
      check("PCF", PCF, m_pc);
      check("StallCntF", StallCntF, m_cnt);
    end
  end

  task automatic step(input logic en, input logic red, input logic [31:0] tgt,
                      input logic ack, input logic [31:0] data);
    EnF = en; RedirectD = red; PCTargetD = tgt; IMemAck = ack; IMemRdata = data;
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t en=%0d red=%0d ack=%0d | req=%0d addr=%08h valid=%0d instr=%08h pc=%08h cnt=%08h",
             $time, en, red, ack, IMemReq, IMemAddr, ValidF, InstrF, PCF, StallCntF);
  endtask

  initial begin
    // Reset, then zero-wait ack on the first request.
    reset = 1'b1;
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_en = 1'b1;
    reset = 1'b0;
    check("rst_req", 32'(IMemReq), 32'd1);
    check("rst_addr", IMemAddr, 32'd0);
    check("rst_cnt", StallCntF, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h2008_0005);
    check("s1_valid", 32'(ValidF), 32'd1);
    check("s1_instr", InstrF, 32'h2008_0005);
    check("s1_pcplus4", PCPlus4F, 32'd4);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check("s1_next_addr", IMemAddr, 32'd4);

    // Walk to a request at 0x10, then a three-cycle memory wait.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b1, 32'hA000_0000 + 32'(i));
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    end
    check("s2_cnt_before", StallCntF, 32'd4);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      check("s2_addr_stable", IMemAddr, 32'h10);
      check("s2_bubble", InstrF, 32'd0);
    end
    check("s2_cnt_after", StallCntF, 32'd7);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'hB000_0010);
    check("s2_pc", PCF, 32'h10);

    // Redirect while a request at 0x20 is in flight.
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b1, 32'hC000_0000 + 32'(i));
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    end
    check("s3_addr20", IMemAddr, 32'h20);
    step(1'b1, 1'b1, 32'h100, 1'b0, 32'd0);
    check("s3_pc_target", PCF, 32'h100);
    check("s3_addr_hold", IMemAddr, 32'h20);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
    check("s3_discard", 32'(ValidF), 32'd0);
    check("s3_rereq", IMemAddr, 32'h100);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0100);
    check("s3_valid", 32'(ValidF), 32'd1);
    check("s3_pc", PCF, 32'h100);

    // READY at 0x40 stalled for four cycles; acks and redirects are ignored.
    step(1'b1, 1'b1, 32'h40, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'hDEAD_0040);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h999, 1'b1, 32'h5555_0000 + 32'(i));
      check("s4_pc_frozen", PCF, 32'h40);
      check("s4_instr_frozen", InstrF, 32'hDEAD_0040);
      check("s4_noreq", 32'(IMemReq), 32'd0);
    end
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check("s4_addr44", IMemAddr, 32'h44);

    // Ack accepted during a stall, then redirect with unaligned target.
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0044);
    check("s5_stall_ack", 32'(ValidF), 32'd1);
    step(1'b1, 1'b1, 32'h203, 1'b0, 32'd0);
    check("s5_pc_align", PCF, 32'h200);
    check("s5_addr_align", IMemAddr, 32'h200);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);

    // Counter saturation from 0xFFFFFFFE.
    #2;
    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_reg;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check("s6_saturate", StallCntF, 32'hFFFF_FFFF);

    // PC+4 wraps at the top of the address space.
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0204);
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h7777_7777);
    check("wrap_pcplus4", PCPlus4F, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check("wrap_addr", IMemAddr, 32'd0);

    // Reset while a kill is pending; the next ack must be accepted.
    step(1'b1, 1'b1, 32'h80, 1'b0, 32'd0);
    reset = 1'b1;
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h9999_9999);
    reset = 1'b0;
    check("rst2_pc", PCF, 32'd0);
    check("rst2_cnt", StallCntF, 32'd0);
    check("rst2_addr", IMemAddr, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_1234);
    check("rst2_kill_cleared", InstrF, 32'h0000_1234);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL expose the following ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- EnF  in  1  fetch-stage advance enable from the hazard unit; 0 = stall.
- RedirectD  in  1  taken branch/jump from decode; sampled only when EnF=1.
- PCTargetD  in  32  redirect target.
- IMemReq  out  1  instruction-memory request.
- IMemAddr  out  32  request address; stable while IMemReq=1.
- IMemAck  in  1  one-cycle data-valid pulse; may arrive in the same cycle as IMemReq.
- IMemRdata  in  32  instruction word, valid when IMemAck=1.
- InstrF  out  32  fetched instruction to the IF/ID register.
- PCPlus4F  out  32  PCF+4 to the IF/ID register.
- PCF  out  32  address of the instruction held or being fetched.
- ValidF  out  1  InstrF/PCPlus4F carry a real instruction.
- StallCntF  out  32  performance counter.

Function
REQ-003 The block SHALL implement two states:
- REQ: IMemReq=1, IMemAddr=ReqAddr.
- READY: IMemReq=0, instruction buffered.
REQ-004 In READY, ValidF SHALL be 1, InstrF SHALL equal the buffer and PCPlus4F SHALL equal PCF+4; in REQ, ValidF=0 and InstrF=PCPlus4F=0 (NOP bubble).
REQ-005 PCF+4 SHALL wrap modulo 2^32; PCTargetD[1:0] SHALL be forced to 00 when loaded.
REQ-006 Next PC SHALL be PCTargetD if RedirectD=1, else PCF+4.
REQ-007 Next PC SHALL be applied only on an edge with EnF=1; with EnF=0, PCF, ReqAddr, buffer and state SHALL hold, except that IMemAck SHALL still be accepted in REQ.
REQ-008 REQ, IMemAck=1, no kill pending, no redirect this edge: the block SHALL capture IMemRdata into the buffer and go to READY.
REQ-009 REQ, EnF=1, RedirectD=1, no ack: PCF SHALL load the target, ReqAddr SHALL hold and the kill flag SHALL set.
REQ-010 REQ, IMemAck=1 with kill set or a redirect this edge: the block SHALL discard the data, load ReqAddr with the newest PCF, clear kill and stay in REQ.
REQ-011 REQ, EnF=1, RedirectD=0, no ack: PCF SHALL NOT advance, because a bubble is being consumed.
REQ-012 READY, EnF=1: PCF and ReqAddr SHALL load the next PC and the state SHALL go to REQ; with RedirectD=1 the buffered instruction is dropped (IF/ID flush is external).
REQ-013 READY, EnF=0: all state SHALL hold and IMemAck SHALL be ignored.
REQ-014 Minimum issue interval SHALL be 2 cycles per instruction with zero-wait memory.
REQ-015 StallCntF SHALL increment on each edge with EnF=1 and ValidF=0, and SHALL saturate at 0xFFFFFFFF.

Reset
REQ-016 On reset, the block SHALL set PCF=0, ReqAddr=0, buffer=0, kill=0, StallCntF=0 and state=REQ.
REQ-017 In the first cycle after reset, the block SHALL drive IMemReq=1 and IMemAddr=0.
REQ-018 Reset SHALL override every other input; a pending request or kill SHALL be abandoned and a late IMemAck for it SHALL be ignored unless the block has re-entered REQ.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset, EnF=1, ack immediately with 0x20080005 -> cycle 1: ValidF=1, InstrF=0x20080005, PCPlus4F=4; next request IMemAddr=4.
- Ack delayed 3 cycles at PCF=0x10 -> IMemAddr=0x10 stable for all 3 cycles, InstrF=0, StallCntF +3.
- REQ at 0x20, redirect to 0x100 with EnF=1, ack next cycle -> data discarded, IMemAddr=0x100, then ValidF=1 with PCF=0x100.
- READY at 0x40, EnF=0 for 4 cycles -> outputs frozen, IMemReq=0; then EnF=1 -> IMemAddr=0x44.
- READY, EnF=1, RedirectD=1, PCTargetD=0x203 -> PCF=0x200, IMemAddr=0x200.
- Force StallCntF to 0xFFFFFFFE, 3 stalled cycles -> counter ends at 0xFFFFFFFF.
